// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the mips_cpu_bus arbiter: FSM states, client IDs, full byte mask.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    DONE
  } state_e;

  typedef enum logic {
    CLIENT_F,
    CLIENT_D
  } client_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_arb_pick.sv
// Combinational winner select between fetch (F) and data (D) requesters.
// Define MIPS_BUS_ARB_RR_EN for round-robin; otherwise D has fixed priority over F.
module mips_cpu_bus_arb_pick
  import mips_cpu_bus_pkg::*;
(
  input  logic    f_req,
  input  logic    d_req,
`ifdef MIPS_BUS_ARB_RR_EN
  input  client_e last_grant,
`endif
  output client_e winner
);

  always_comb begin
`ifdef MIPS_BUS_ARB_RR_EN
    // On a tie, the client that was not granted last time wins.
    if (f_req && d_req) begin
      winner = (last_grant == CLIENT_D) ? CLIENT_F : CLIENT_D;
    end else begin
      winner = (f_req && !d_req) ? CLIENT_F : CLIENT_D;
    end
`else
    winner = (f_req && !d_req) ? CLIENT_F : CLIENT_D;
`endif
  end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one Avalon-MM master between instruction fetch (F) and load/store (D).
// Define MIPS_BUS_ARB_RR_EN for round-robin arbitration; default is fixed D-over-F priority.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_ack,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                busy,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state_q, state_d;
  client_e           winner_q, winner_d;
  client_e           pick;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [BE_W-1:0]   byteenable_q, byteenable_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

`ifdef MIPS_BUS_ARB_RR_EN
  client_e last_grant_q, last_grant_d;

  assign last_grant_d = (state_q == IDLE && (f_req || d_req)) ? pick : last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= CLIENT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  mips_cpu_bus_arb_pick u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .winner     (pick)
  );
`else
  mips_cpu_bus_arb_pick u_pick (
    .f_req  (f_req),
    .d_req  (d_req),
    .winner (pick)
  );
`endif

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          winner_d = pick;
          state_d  = ACCESS;
          if (pick == CLIENT_D) begin
            address_d    = d_addr & ALIGN_MASK;
            writedata_d  = d_wdata;
            byteenable_d = d_be;
            read_d       = !d_we;
            write_d      = d_we;
          end else begin
            address_d    = f_addr & ALIGN_MASK;
            byteenable_d = BE_ALL;
            read_d       = 1'b1;
            write_d      = 1'b0;
          end
        end
      end
      ACCESS: begin
        // Bus registers stay frozen until the slave stops stalling.
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            state_d = RESP;
          end else begin
            state_d = DONE;
            f_ack_d = (winner_q == CLIENT_F);
            d_ack_d = (winner_q == CLIENT_D);
          end
        end
      end
      RESP: begin
        state_d = DONE;
        if (winner_q == CLIENT_D) begin
          d_rdata_d = readdata;
        end else begin
          f_rdata_d = readdata;
        end
        f_ack_d = (winner_q == CLIENT_F);
        d_ack_d = (winner_q == CLIENT_D);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      winner_q     <= CLIENT_F;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign f_ack      = f_ack_q;
  assign d_ack      = d_ack_q;
  assign f_rdata    = f_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter; expectations follow MIPS_BUS_ARB_RR_EN when defined.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        f_ack, d_ack, busy, read, write;
  logic [31:0] f_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  int checks = 0, fails = 0;
  int cyc = 0, wait_left = 0;
  int f_acks = 0, d_acks = 0, reads_seen = 0, writes_seen = 0;
  logic prev_f_ack = 1'b0, prev_d_ack = 1'b0, prev_read = 1'b0, prev_write = 1'b0;
  logic auto_drop = 1'b1;

  mips_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'hBFC00000) ? 32'h24020005 : (a ^ 32'h5A5A5A5A);
  endfunction

  // One clock: slave model, client auto-drop, ack/transfer bookkeeping, bus invariants.
  task automatic cycle();
    logic        acc;
    logic [31:0] acc_addr;
    acc      = read && !waitrequest;
    acc_addr = address;
    @(posedge clk);
    #1;
    cyc++;
    readdata = acc ? mem_word(acc_addr) : 32'h0BAD0BAD;
    if ((read || write) && wait_left > 0) begin
      waitrequest = 1'b1;
      wait_left--;
    end else begin
      waitrequest = 1'b0;
    end
    if (f_ack) f_acks++;
    if (d_ack) d_acks++;
    if (read && !prev_read) reads_seen++;
    if (write && !prev_write) writes_seen++;
    if (auto_drop && f_ack) f_req = 1'b0;
    if (auto_drop && d_ack) d_req = 1'b0;
    checks++;
    if ((read && write) !== 1'b0) begin
      fails++; $display("FAIL rw_exclusive cyc=%0d: read=%b write=%b, required not both high", cyc, read, write);
    end
    checks++;
    if ((f_ack && prev_f_ack) || (d_ack && prev_d_ack)) begin
      fails++; $display("FAIL ack_one_cycle cyc=%0d: ack high two cycles running, required single pulse", cyc);
    end
    prev_f_ack = f_ack; prev_d_ack = d_ack; prev_read = read; prev_write = write;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({read, write, f_ack, d_ack, busy} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: {read,write,f_ack,d_ack,busy}=%b, required 00000", {read, write, f_ack, d_ack, busy});
    end
    checks++;
    if ({address, writedata} !== 64'h0) begin
      fails++; $display("FAIL reset_bus: address=%h writedata=%h, required 0", address, writedata);
    end
    checks++;
    if (byteenable !== 4'h0) begin
      fails++; $display("FAIL reset_be: got %h, required 0", byteenable);
    end
    checks++;
    if ({f_rdata, d_rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_rdata: f_rdata=%h d_rdata=%h, required 0", f_rdata, d_rdata);
    end
    $display("reset: busy=%b read=%b write=%b", busy, read, write);
  endtask

  task automatic test_fetch_read();
    f_addr = 32'hBFC00002;
    f_req  = 1'b1;
    cycle();
    checks++;
    if ({read, write, busy} !== 3'b101) begin
      fails++; $display("FAIL fetch_start: {read,write,busy}=%b, required 101", {read, write, busy});
    end
    checks++;
    if (address !== 32'hBFC00000 || byteenable !== 4'hF) begin
      fails++; $display("FAIL fetch_bus: address=%h be=%h, required bfc00000/f", address, byteenable);
    end
    cycle();
    checks++;
    if (read !== 1'b0 || f_ack !== 1'b0) begin
      fails++; $display("FAIL fetch_resp: read=%b f_ack=%b, required 0/0", read, f_ack);
    end
    cycle();
    checks++;
    if (f_ack !== 1'b1 || d_ack !== 1'b0 || f_rdata !== 32'h24020005) begin
      fails++; $display("FAIL fetch_ack: f_ack=%b d_ack=%b f_rdata=%h, required 1/0/24020005", f_ack, d_ack, f_rdata);
    end
    cycle();
    checks++;
    if (f_ack !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL fetch_idle: f_ack=%b busy=%b, required 0/0", f_ack, busy);
    end
    $display("fetch read: addr=%h data=%h", address, f_rdata);
  endtask

  task automatic test_data_write_waits();
    d_we = 1'b1; d_addr = 32'h00001000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    wait_left = 2;
    d_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({read, write, d_ack} !== 3'b010 || address !== 32'h00001000 ||
          writedata !== 32'hDEADBEEF || byteenable !== 4'b0011) begin
        fails++; $display("FAIL write_hold[%0d]: rwa=%b addr=%h wd=%h be=%h, required 010/1000/deadbeef/3",
                          i, {read, write, d_ack}, address, writedata, byteenable);
      end
    end
    cycle();
    checks++;
    if (d_ack !== 1'b1 || write !== 1'b0 || f_ack !== 1'b0) begin
      fails++; $display("FAIL write_ack: d_ack=%b write=%b f_ack=%b, required 1/0/0", d_ack, write, f_ack);
    end
    cycle();
    checks++;
    if (d_ack !== 1'b0 || busy !== 1'b0 || f_rdata !== 32'h24020005 || d_rdata !== 32'h0) begin
      fails++; $display("FAIL write_after: d_ack=%b busy=%b f_rdata=%h d_rdata=%h, required 0/0/24020005/0",
                        d_ack, busy, f_rdata, d_rdata);
    end
    d_we = 1'b0;
    $display("data write with 2 waits: addr=00001000 data=deadbeef be=3");
  endtask

  task automatic test_tie();
    int fa, da, exp_fa, exp_da;
    logic [31:0] fad, dad;
`ifdef MIPS_BUS_ARB_RR_EN
    exp_fa = 3; exp_da = 7;
`else
    exp_fa = 7; exp_da = 3;
`endif
    do_reset();
    for (int t = 0; t < 2; t++) begin
      fad = 32'h00000100 + 32'(4 * t);
      dad = 32'h00002004 + 32'(4 * t);
      f_addr = fad; d_addr = dad; d_we = 1'b0; d_be = 4'hF;
      fa = -1; da = -1;
      f_req = 1'b1; d_req = 1'b1;
      for (int i = 1; i <= 12; i++) begin
        cycle();
        if (f_ack && fa < 0) fa = i;
        if (d_ack && da < 0) da = i;
      end
      checks++;
      if (fa !== exp_fa || da !== exp_da) begin
        fails++; $display("FAIL tie_order[%0d]: f_ack at %0d d_ack at %0d, required %0d/%0d", t, fa, da, exp_fa, exp_da);
      end
      checks++;
      if (f_rdata !== (fad ^ 32'h5A5A5A5A) || d_rdata !== (dad ^ 32'h5A5A5A5A)) begin
        fails++; $display("FAIL tie_rdata[%0d]: f_rdata=%h d_rdata=%h, required %h/%h",
                          t, f_rdata, d_rdata, fad ^ 32'h5A5A5A5A, dad ^ 32'h5A5A5A5A);
      end
      $display("tie %0d: f_ack at +%0d, d_ack at +%0d", t, fa, da);
    end
  endtask

  task automatic test_req_drop();
    int base_a, base_r;
    base_a = f_acks; base_r = reads_seen;
    f_addr = 32'h00000300;
    f_req  = 1'b1;
    cycle();
    f_req = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    if (f_acks - base_a !== 1 || reads_seen - base_r !== 1) begin
      fails++; $display("FAIL drop_req: acks=%0d reads=%0d, required 1/1", f_acks - base_a, reads_seen - base_r);
    end
    checks++;
    if (f_rdata !== 32'h5A5A595A) begin
      fails++; $display("FAIL drop_rdata: got %h, required 5a5a595a", f_rdata);
    end
    $display("dropped fetch req: data=%h", f_rdata);
  endtask

  task automatic test_reset_mid_access();
    int base_f, base_d;
    base_f = f_acks; base_d = d_acks;
    d_we = 1'b0; d_addr = 32'h00000040; wait_left = 5;
    d_req = 1'b1;
    cycle();
    checks++;
    if (read !== 1'b1 || waitrequest !== 1'b1) begin
      fails++; $display("FAIL rst_mid_setup: read=%b waitrequest=%b, required 1/1", read, waitrequest);
    end
    reset = 1'b1;
    d_req = 1'b0;
    cycle();
    checks++;
    if ({read, write, busy} !== 3'b000) begin
      fails++; $display("FAIL rst_mid: {read,write,busy}=%b, required 000", {read, write, busy});
    end
    reset = 1'b0;
    wait_left = 0;
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (f_acks !== base_f || d_acks !== base_d || busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_noack: f_acks+%0d d_acks+%0d busy=%b, required 0/0/0",
                        f_acks - base_f, d_acks - base_d, busy);
    end
    $display("reset during stalled read: no ack, bus idle");
  endtask

  task automatic test_back_to_back();
    int r1, r2, base_a, base_r;
    base_a = f_acks; base_r = reads_seen;
    r1 = -1; r2 = -1;
    auto_drop = 1'b0;
    f_addr = 32'h00000500;
    f_req  = 1'b1;
    for (int i = 1; i <= 20 && r2 < 0; i++) begin
      cycle();
      if (f_ack) begin
        if (r1 < 0) r1 = i;
        else r2 = i;
      end
    end
    f_req = 1'b0;
    checks++;
    if (r1 !== 3 || r2 !== 7) begin
      fails++; $display("FAIL b2b_timing: acks at %0d/%0d, required 3/7", r1, r2);
    end
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (f_acks - base_a !== 2 || reads_seen - base_r !== 2 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_count: acks=%0d reads=%0d busy=%b, required 2/2/0",
                        f_acks - base_a, reads_seen - base_r, busy);
    end
    auto_drop = 1'b1;
    $display("back-to-back fetch: acks at +%0d and +%0d", r1, r2);
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write_waits();
    test_tie();
    test_req_drop();
    test_reset_mid_access();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
